// File: rtl/muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit.
package muldiv_pkg;
    localparam int MD_WIDTH = 8;
    localparam int MD_ITER  = MD_WIDTH;

    typedef enum logic [1:0] {
        MULLO = 2'b00,
        MULHI = 2'b01,
        DIVQ  = 2'b10,
        DIVR  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        WB   = 2'b10
    } muldiv_state_t;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [CW-1:0]        i_idx,
    output logic [2*WIDTH-1:0]   o_acc
);
    logic [CW-1:0]  w_didx;
    logic           w_mbit;
    logic           w_dbit;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_didx  = CW'(WIDTH - 1) - i_idx;
    assign w_mbit  = i_b[i_idx];
    assign w_dbit  = i_a[w_didx];

    // Multiply: the upper half accumulates, carry kept in bit WIDTH of the sum.
    assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (w_mbit ? {1'b0, i_a} : '0);

    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    assign w_shift = {i_acc[2*WIDTH-1:WIDTH], w_dbit};
    assign w_diff  = w_shift - {1'b0, i_b};

    always_comb begin
        o_acc = '0;
        if (!i_div) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MUL/DIV; result returned through regfile write port 3.
// State | meaning: IDLE wait for start | CALC one iteration per cycle | WB one-cycle write strobe
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             wb_we,
    output logic [AW-1:0]    wb_wa,
    output logic [WIDTH-1:0] wb_wd
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_t      r_state, w_state_nxt;
    muldiv_op_t         r_op, w_op_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [AW-1:0]      r_dst, w_dst_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_wb_we, w_we_nxt;
    logic [AW-1:0]      r_wb_wa, w_wa_nxt;
    logic [WIDTH-1:0]   r_wb_wd, w_wd_nxt;

    logic               w_is_div;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0]   w_result;

    assign w_is_div = (r_op == DIVQ) || (r_op == DIVR);

    muldiv_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
        .i_div (w_is_div),
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_idx (r_cnt),
        .o_acc (w_step_acc)
    );

    // Low half holds product-low or quotient, high half product-high or remainder.
    always_comb begin
        w_result = w_step_acc[WIDTH-1:0];
        case (r_op)
            MULHI, DIVR: w_result = w_step_acc[2*WIDTH-1:WIDTH];
            default:     w_result = w_step_acc[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_dst_nxt   = r_dst;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_we_nxt    = 1'b0;
        w_wa_nxt    = r_wb_wa;
        w_wd_nxt    = r_wb_wd;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_op_nxt    = muldiv_op_t'(op);
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_dst_nxt   = dst;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_acc_nxt = w_step_acc;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WB;
                    w_we_nxt    = 1'b1;
                    w_wa_nxt    = r_dst;
                    w_wd_nxt    = w_result;
                end
            end
            WB: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= MULLO;
            r_a     <= '0;
            r_b     <= '0;
            r_dst   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_wb_we <= 1'b0;
            r_wb_wa <= '0;
            r_wb_wd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_dst   <= w_dst_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_wb_we <= w_we_nxt;
            r_wb_wa <= w_wa_nxt;
            r_wb_wd <= w_wd_nxt;
        end
    end

    assign busy  = r_busy;
    assign wb_we = r_wb_we;
    assign wb_wa = r_wb_wa;
    assign wb_wd = r_wb_wd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: timeline/arithmetic reference model, directed literals, random traffic.
module tb_muldiv_unit;
    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [AW-1:0] dst = '0;
    logic          busy;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [W-1:0]  wb_wd;

    int n_tests = 0;
    int n_fail  = 0;
    int we_count = 0;
    bit mon_en = 1'b0;

    muldiv_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .dst   (dst),
        .busy  (busy),
        .wb_we (wb_we),
        .wb_wa (wb_wa),
        .wb_wd (wb_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Reference: an accepted request occupies the unit for W+1 cycles, write in the last.
    bit            m_active = 1'b0;
    int            m_age = 0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_dst = '0;
    logic [W-1:0]  m_res = '0;
    logic [AW-1:0] m_wa = '0;
    logic [W-1:0]  m_wd = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_age    = 0;
            m_we     = 1'b0;
            m_wa     = '0;
            m_wd     = '0;
        end else begin
            if (m_active) begin
                m_age++;
                if (m_age > W) m_active = 1'b0;
            end else if (start) begin
                m_active = 1'b1;
                m_age    = 0;
                m_res    = ref_res(op, a, b);
                m_dst    = dst;
            end
            m_we = m_active && (m_age == W);
            if (m_we) begin
                m_wa = m_dst;
                m_wd = m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy",  16'(busy),  16'(m_active));
            check("wb_we", 16'(wb_we), 16'(m_we));
            check("wb_wa", 16'(wb_wa), 16'(m_wa));
            check("wb_wd", 16'(wb_wd), 16'(m_wd));
        end
        if (wb_we === 1'b1) we_count++;
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [AW-1:0] d, input bit poke,
                          output logic [W-1:0] wd, output logic [AW-1:0] wa,
                          output int lat, output int bcnt);
        @(negedge clk);
        op = o; a = x; b = y; dst = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); dst = 3'($urandom);
        lat = 1;
        bcnt = 0;
        while (wb_we !== 1'b1 && lat < 30) begin
            if (busy === 1'b1) bcnt++;
            start = poke && (lat == 3);
            if (start) begin
                op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); dst = 3'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) bcnt++;
        wd = wb_wd;
        wa = wb_wa;
        start = poke;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  wd;
        logic [AW-1:0] wa;
        int lat, bcnt, w0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  16'(busy),  16'h0);
        check("rst_wb_we", 16'(wb_we), 16'h0);
        check("rst_wb_wa", 16'(wb_wa), 16'h0);
        check("rst_wb_wd", 16'(wb_wd), 16'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_op(2'b00, 8'h0D, 8'h0B, 3'd5, 1'b0, wd, wa, lat, bcnt);
        check("mullo13x11_lat",  16'(lat),  16'd9);
        check("mullo13x11_busy", 16'(bcnt), 16'd9);
        check("mullo13x11_wa",   16'(wa),   16'd5);
        check("mullo13x11_wd",   16'(wd),   16'h8F);

        run_op(2'b01, 8'hFF, 8'hFF, 3'd1, 1'b0, wd, wa, lat, bcnt);
        check("mulhi_ffxff", 16'(wd), 16'hFE);
        run_op(2'b00, 8'hFF, 8'hFF, 3'd2, 1'b0, wd, wa, lat, bcnt);
        check("mullo_ffxff", 16'(wd), 16'h01);

        run_op(2'b10, 8'hC8, 8'h07, 3'd3, 1'b0, wd, wa, lat, bcnt);
        check("divq_200_7", 16'(wd), 16'h1C);
        run_op(2'b11, 8'hC8, 8'h07, 3'd4, 1'b0, wd, wa, lat, bcnt);
        check("divr_200_7", 16'(wd), 16'h04);

        run_op(2'b10, 8'h5A, 8'h00, 3'd6, 1'b0, wd, wa, lat, bcnt);
        check("divq_by0",     16'(wd),  16'hFF);
        check("divq_by0_lat", 16'(lat), 16'd9);
        run_op(2'b11, 8'h5A, 8'h00, 3'd7, 1'b0, wd, wa, lat, bcnt);
        check("divr_by0", 16'(wd), 16'h5A);

        w0 = we_count;
        run_op(2'b10, 8'h64, 8'h09, 3'd3, 1'b1, wd, wa, lat, bcnt);
        repeat (3) @(negedge clk);
        check("poke_divq_wd", 16'(wd), 16'h0B);
        check("poke_divq_wa", 16'(wa), 16'd3);
        check("poke_one_we",  16'(we_count - w0), 16'd1);

        @(negedge clk);
        op = 2'b00; a = 8'h37; b = 8'h2B; dst = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",  16'(busy),  16'h0);
        check("abort_wb_we", 16'(wb_we), 16'h0);
        check("abort_wb_wa", 16'(wb_wa), 16'h0);
        check("abort_wb_wd", 16'(wb_wd), 16'h0);
        rst_n = 1'b1;
        w0 = we_count;
        repeat (15) @(negedge clk);
        check("abort_no_we", 16'(we_count - w0), 16'd0);
        run_op(2'b01, 8'h37, 8'h2B, 3'd6, 1'b0, wd, wa, lat, bcnt);
        check("after_abort_wd", 16'(wd), 16'h09);
        check("after_abort_wa", 16'(wa), 16'd6);

        repeat (2000) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 249) != 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            a     = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dst   = 3'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
